logic_unit_seq: RTL and testbench
=================================

# logic_unit_seq

Registered, handshaked successor to the combinational logic unit. It takes one operation at a time on a valid/ready input port and performs one of eight bitwise operations on WIDTH-bit operands. Results and Z/N/P flags are returned on a valid/ready output port. Seven operations complete in one cycle; rotate-left is iterative, one bit position per cycle. It sits between the operand-fetch stage and the writeback/flag register of the datapath.

## Interface
- WIDTH, 16, operand/result width; power of two, ≥ 4. AW = $clog2(WIDTH).
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation offered.
- in_ready  output  1  block can accept; transfer when in_valid & in_ready at rising edge.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B; for ROL only B[AW-1:0] used (rotate amount).
- F  input  3  opcode: 000 AND, 001 OR, 010 XOR, 011 NOT A, 100 NAND, 101 NOR, 110 XNOR, 111 ROL A by B[AW-1:0].
- out_valid  output  1  result held on Out/Z/N/P.
- out_ready  input  1  consumer takes result; transfer when out_valid & out_ready at rising edge.
- Out  output  WIDTH  registered result.
- Z  output  1  Out == 0.
- N  output  1  Out[WIDTH-1].
- P  output  1  even-parity flag, ~^Out (1 when popcount of Out even).
- busy  output  1  rotate in progress (state ROT).

## Operation
- States: IDLE, ROT. Output register (Out, Z, N, P, out_valid) is a single slot independent of state.
- in_ready = rst_n & (state == IDLE) & (~out_valid | out_ready); combinational.
- IDLE, accept F≠111: compute result, load Out/Z/N/P, set out_valid; stay IDLE.
- IDLE, accept F=111, amount = B[AW-1:0]:
  - amount == 0: load Out = A, flags, set out_valid; stay IDLE.
  - amount ≠ 0: load shift reg = A, cnt = amount; go ROT.
- ROT, each cycle: shift reg rotated left 1 (bit WIDTH-1 → bit 0), cnt decrements.
- ROT, cnt == 1: rotated value written to Out with flags, out_valid set, return IDLE.
- Upper bits B[WIDTH-1:AW] ignored for ROL. A never rotates by ≥ WIDTH.
- Rotate may not complete into an occupied slot. Entry to ROT requires in_ready, and in_ready already guarantees the slot is free or being drained. The slot is then empty by completion unless out_valid was re-set, which cannot happen in ROT.
- Output slot: out_valid & out_ready with no new result → out_valid cleared. Drain and new load in the same edge → new result replaces old, out_valid stays 1.
- Out/Z/N/P hold value while out_valid & ~out_ready. They also hold their last value after drain; no bubble zeroing.
- Flags are always computed from the WIDTH-bit result being loaded, for all opcodes.
- in_valid while ~in_ready: A/B/F ignored, nothing captured; the source must hold.

## Timing
- Reset (rst_n low, asynchronous): state IDLE, out_valid 0, Out 0, Z 0, N 0, P 0, busy 0, in_ready 0, shift reg/cnt 0. First acceptance is possible on the first rising edge after rst_n rises.
- Reset mid-ROT or with a held result: operation and result discarded, no output produced.
- Latency from accept edge to out_valid high:
  - 1 cycle for F≠111 and for ROL with amount 0.
  - amount cycles for ROL with amount ≥ 1 (max WIDTH-1).
- Throughput: 1 op/cycle for non-ROL with out_ready held 1. ROL blocks input for amount cycles (in_ready 0 while busy).
- busy is 1 from the edge after ROT entry until the completing edge.

## Test plan
- AND A=F0F0 B=FF00, out_ready=1 → next cycle out_valid=1, Out=F000, Z0 N1 P1. NOT A=FFFF → Out=0000, Z1 N0 P1. XOR A=0001 B=0000 → Out=0001, Z0 N0 P0.
- Back-to-back NAND FFFF/FFFF, NOR 0000/0000, XNOR 1234/1234 every cycle, out_ready=1 → in_ready stays 1. Outputs on consecutive cycles: 0000 (Z1), FFFF (N1 P1), FFFF.
- ROL A=8001 B=0004 → busy and in_ready=0 for 4 cycles, out_valid 4 cycles after accept, Out=0018, Z0 N0 P1. ROL A=ABCD B=0010 (amount 0) → Out=ABCD after 1 cycle, busy never 1.
- Backpressure: out_ready=0, OR 00F0/0F00 accepted, then AND offered → in_ready=0, Out=0FF0 held 5 cycles. Raise out_ready → AND accepted on the drain edge, its result replaces Out next edge with out_valid continuous.
- Async reset: ROL A=0001 B=000F started, rst_n pulsed low in cycle 3 (mid-edge) → outputs immediately 0, busy 0. After release no out_valid appears until a new op is accepted.
- WIDTH=8 instance: ROL A=81 B=FF (amount 7) → Out=C0 after 7 cycles, P1 N1.

Source files
------------

// File: rtl/logic_unit_seq_if.sv
// Handshake bundle for logic_unit_seq: operation request port and result port.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready carry flow control in each direction.
interface logic_unit_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       F;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Out;
  logic             Z;
  logic             N;
  logic             P;
  logic             busy;

  // Producer of operations / consumer of results
  modport master (
    output in_valid, A, B, F, out_ready,
    input  in_ready, out_valid, Out, Z, N, P, busy
  );

  // The logic unit itself
  modport slave (
    input  in_valid, A, B, F, out_ready,
    output in_ready, out_valid, Out, Z, N, P, busy
  );
endinterface

// File: rtl/logic_unit_seq.sv
// Registered bitwise logic unit (AND/OR/XOR/NOT/NAND/NOR/XNOR/ROL) with Z/N/P flags.
// Latency: 1 cycle, except ROL by n>0 which takes n cycles (one bit per cycle).
// Backpressure: single output slot; in_ready drops while rotating or while the slot is full and not draining.
module logic_unit_seq #(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  logic_unit_seq_if.slave bus
);

  localparam int AW = $clog2(WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    ROT  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sh;
  logic [AW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_out;
  logic             r_z;
  logic             r_n;
  logic             r_p;
  logic             r_ovld;

  logic             w_in_ready;
  logic             w_accept;
  logic [AW-1:0]    w_amt;
  logic             w_is_rol;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_rot;
  logic             w_ld_en;
  logic [WIDTH-1:0] w_ld_val;

  // Accept only when idle and the output slot is empty or draining this edge.
  assign w_in_ready = rst_n & (r_state == IDLE) & (~r_ovld | bus.out_ready);
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_amt      = bus.B[AW-1:0];
  assign w_is_rol   = (bus.F == 3'b111);
  assign w_rot      = {r_sh[WIDTH-2:0], r_sh[WIDTH-1]};

  // Single-cycle result for the accepted opcode; ROL here only covers the zero-amount case.
  always_comb begin
    w_res = '0;
    case (bus.F)
      3'b000:  w_res = bus.A & bus.B;
      3'b001:  w_res = bus.A | bus.B;
      3'b010:  w_res = bus.A ^ bus.B;
      3'b011:  w_res = ~bus.A;
      3'b100:  w_res = ~(bus.A & bus.B);
      3'b101:  w_res = ~(bus.A | bus.B);
      3'b110:  w_res = ~(bus.A ^ bus.B);
      default: w_res = bus.A;
    endcase
  end

  // Output slot load: immediate ops from IDLE, or the final rotate step from ROT.
  always_comb begin
    w_ld_en  = 1'b0;
    w_ld_val = w_res;
    if (r_state == ROT) begin
      w_ld_en  = (r_cnt == AW'(1));
      w_ld_val = w_rot;
    end else begin
      w_ld_en  = w_accept & (~w_is_rol | (w_amt == '0));
    end
  end

  // Control FSM, rotate datapath and output slot with flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sh    <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_z     <= 1'b0;
      r_n     <= 1'b0;
      r_p     <= 1'b0;
      r_ovld  <= 1'b0;
    end else begin
      // Drain first; a load on the same edge overrides and keeps the slot valid.
      if (r_ovld && bus.out_ready) begin
        r_ovld <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_accept && w_is_rol && (w_amt != '0)) begin
            r_sh    <= bus.A;
            r_cnt   <= w_amt;
            r_state <= ROT;
          end
        end
        ROT: begin
          r_sh  <= w_rot;
          r_cnt <= r_cnt - AW'(1);
          if (r_cnt == AW'(1)) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_ld_en) begin
        r_out  <= w_ld_val;
        r_z    <= (w_ld_val == '0);
        r_n    <= w_ld_val[WIDTH-1];
        r_p    <= ~(^w_ld_val);
        r_ovld <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_ovld;
  assign bus.Out       = r_out;
  assign bus.Z         = r_z;
  assign bus.N         = r_n;
  assign bus.P         = r_p;
  assign bus.busy      = (r_state == ROT);

endmodule

// File: tb/tb_logic_unit_seq.sv
// Testbench for logic_unit_seq: WIDTH=16 instance with result scoreboard, WIDTH=8 rotate instance.
// Latency: checks 1-cycle ops and n-cycle rotates.
// Backpressure: exercises held results, blocked input and drain-with-reload.
module tb_logic_unit_seq;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic_unit_seq_if #(.WIDTH(16)) b16 ();
  logic_unit_seq_if #(.WIDTH(8))  b8 ();

  logic_unit_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  logic_unit_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));

  int n_pass = 0;
  int n_chk  = 0;
  int stalls = 0;
  logic [18:0] sb_q[$];
  logic [18:0] mon_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Expected {P, N, Z, Out} for the 16-bit unit.
  function automatic logic [18:0] model16(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] f);
    logic [15:0] r;
    int amt;
    amt = int'(b[3:0]);
    case (f)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~a;
      3'd4: r = ~(a & b);
      3'd5: r = ~(a | b);
      3'd6: r = ~(a ^ b);
      default: r = (amt == 0) ? a : ((a << amt) | (a >> (16 - amt)));
    endcase
    return {~(^r), r[15], (r == 16'h0000), r};
  endfunction

  // Scoreboard consumer: every result transfer is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && b16.out_valid && b16.out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_out", 32'(b16.out_valid), 32'd0);
      end else begin
        mon_exp = sb_q.pop_front();
        check("result", {13'd0, b16.P, b16.N, b16.Z, b16.Out}, {13'd0, mon_exp});
      end
    end
  end

  // Offer one op; called just after a rising edge, returns just after the accept edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [2:0] f);
    int w;
    w = 0;
    b16.A = a; b16.B = b; b16.F = f; b16.in_valid = 1'b1;
    @(negedge clk);
    while (!b16.in_ready && w < 50) begin
      w++;
      @(negedge clk);
    end
    stalls = w;
    if (w >= 50) check("send_timeout", 32'(b16.in_ready), 32'd1);
    else sb_q.push_back(model16(a, b, f));
    @(posedge clk); #1;
    b16.in_valid = 1'b0;
  endtask

  // After an accept: count idle cycles before out_valid, and busy / in_ready-low cycles.
  task automatic measure(output int w, output int bc, output int irc);
    w = 0; bc = 0; irc = 0;
    @(negedge clk);
    while (!b16.out_valid && w < 40) begin
      if (b16.busy) bc++;
      if (!b16.in_ready) irc++;
      w++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, bc, irc, cnt;
    rst_n = 1'b0;
    b16.in_valid = 1'b0; b16.A = '0; b16.B = '0; b16.F = '0; b16.out_ready = 1'b1;
    b8.in_valid  = 1'b0; b8.A  = '0; b8.B  = '0; b8.F  = '0; b8.out_ready  = 1'b1;

    // Reset state
    #12;
    check("rst_ovld",  32'(b16.out_valid), 32'd0);
    check("rst_out",   32'(b16.Out), 32'd0);
    check("rst_flags", 32'({b16.Z, b16.N, b16.P}), 32'd0);
    check("rst_busy",  32'(b16.busy), 32'd0);
    check("rst_inrdy", 32'(b16.in_ready), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic ops with 1-cycle latency
    send(16'hF0F0, 16'hFF00, 3'b000);
    @(negedge clk);
    check("and_lat", 32'(b16.out_valid), 32'd1);
    @(posedge clk); #1;
    send(16'hFFFF, 16'h0000, 3'b011);
    send(16'h0001, 16'h0000, 3'b010);
    send(16'h1234, 16'h00FF, 3'b001);

    // Back-to-back, input never stalls
    send(16'hFFFF, 16'hFFFF, 3'b100);
    check("b2b_nand_stall", 32'(stalls), 32'd0);
    send(16'h0000, 16'h0000, 3'b101);
    check("b2b_nor_stall", 32'(stalls), 32'd0);
    send(16'h1234, 16'h1234, 3'b110);
    check("b2b_xnor_stall", 32'(stalls), 32'd0);
    repeat (2) @(posedge clk); #1;

    // ROL by 4
    send(16'h8001, 16'h0004, 3'b111);
    measure(w, bc, irc);
    check("rol4_lat",   32'(w),   32'd4);
    check("rol4_busy",  32'(bc),  32'd4);
    check("rol4_inrdy", 32'(irc), 32'd4);
    @(posedge clk); #1;

    // ROL by 0 (upper B bits ignored)
    send(16'hABCD, 16'h0010, 3'b111);
    measure(w, bc, irc);
    check("rol0_lat",  32'(w),  32'd0);
    check("rol0_busy", 32'(bc), 32'd0);
    @(posedge clk); #1;

    // ROL by 15
    send(16'h0003, 16'hFFFF, 3'b111);
    measure(w, bc, irc);
    check("rol15_lat", 32'(w), 32'd15);
    @(posedge clk); #1;

    // Backpressure: result held, input blocked, then drain with reload
    b16.out_ready = 1'b0;
    send(16'h00F0, 16'h0F00, 3'b001);
    b16.A = 16'h3C3C; b16.B = 16'h0FF0; b16.F = 3'b000; b16.in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_inrdy", 32'(b16.in_ready), 32'd0);
      check("bp_hold",  32'({b16.out_valid, b16.Out}), 32'h10FF0);
    end
    @(posedge clk); #1;
    b16.out_ready = 1'b1;
    @(negedge clk);
    check("bp_drain_rdy", 32'(b16.in_ready), 32'd1);
    sb_q.push_back(model16(16'h3C3C, 16'h0FF0, 3'b000));
    @(posedge clk); #1;
    b16.in_valid = 1'b0;
    @(negedge clk);
    check("bp_cont", 32'({b16.out_valid, b16.Out}), 32'h10C30);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a rotate
    send(16'h0001, 16'h000F, 3'b111);
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_ovld",  32'(b16.out_valid), 32'd0);
    check("arst_out",   32'(b16.Out), 32'd0);
    check("arst_busy",  32'(b16.busy), 32'd0);
    check("arst_flags", 32'({b16.Z, b16.N, b16.P}), 32'd0);
    sb_q.delete();
    @(negedge clk); rst_n = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (b16.out_valid || b16.busy) cnt++;
    end
    check("arst_no_out", 32'(cnt), 32'd0);
    @(posedge clk); #1;
    send(16'h5555, 16'h00FF, 3'b101);
    @(negedge clk);
    check("post_rst_lat", 32'(b16.out_valid), 32'd1);
    @(posedge clk); #1;

    // WIDTH=8 instance: ROL 0x81 by 7 (B=FF, upper bits ignored)
    b8.A = 8'h81; b8.B = 8'hFF; b8.F = 3'b111; b8.in_valid = 1'b1;
    @(negedge clk);
    check("w8_inrdy", 32'(b8.in_ready), 32'd1);
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    w = 0;
    @(negedge clk);
    while (!b8.out_valid && w < 40) begin
      w++;
      @(negedge clk);
    end
    check("w8_lat", 32'(w), 32'd7);
    check("w8_res", 32'({b8.P, b8.N, b8.Z, b8.Out}), 32'({1'b1, 1'b1, 1'b0, 8'hC0}));

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
